f2i_stream_accum: RTL and testbench



---
 rtl/f2i_pkg.sv | 19 +
 rtl/f2i_stream_accum_sat_add_signed.sv | 25 ++
 rtl/f2i_stream_accum.sv | 156 +++++++++++++++
 tb/tb_f2i_stream_accum.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f2i_pkg.sv
// Shared types and constants for the float-to-int result accumulator.
package f2i_pkg;

    // Per-beat exception flags, also the layout of the sticky flag vector.
    typedef struct packed {
        logic invalid;
        logic denorm;
        logic p_lost;
    } f2i_flags_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } accum_state_t;

    // The converter drives this value on in_d whenever it flags a beat invalid.
    localparam logic [31:0] F2I_INVALID_SENTINEL = 32'h8000_0000;

endpackage

// File: rtl/f2i_stream_accum_sat_add_signed.sv
// Signed W-bit adder whose result clamps to the W-bit signed range.
// ovf_o is set whenever the result was clamped.
module sat_add_signed #(
    parameter int W = 48
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] full;

    assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

    // The top two bits of the W+1-bit sum differ exactly when it does not fit in W bits.
    always_comb begin
        ovf_o = full[W] ^ full[W-1];
        sum_o = full[W-1:0];
        if (ovf_o) begin
            sum_o = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/f2i_stream_accum.sv
// Frame accumulator for float-to-int converter results.
// Each frame ends on the beat with in_last set. For that frame the block keeps a
// saturating signed sum, a beat count and an invalid-beat count. The
// exception flags are sticky across frames.
// Optional: define F2I_ACCUM_MINMAX_EN to add per-frame min/max of valid beats.
//
// state | meaning
// ACCUM | accepting beats of the current frame
// HOLD  | frame result presented on out_*, waiting for out_ready
module f2i_stream_accum
    import f2i_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_d,
    input  logic             in_p_lost,
    input  logic             in_denorm,
    input  logic             in_invalid,
    input  logic             in_last,
    input  logic             clr_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_inv_count,
    output logic             out_ovf,
`ifdef F2I_ACCUM_MINMAX_EN
    output logic [31:0]      out_min,
    output logic [31:0]      out_max,
`endif
    output logic [2:0]       sticky_flags
);

    localparam logic [31:0] MIN_INIT = 32'h7FFF_FFFF;
    localparam logic [31:0] MAX_INIT = 32'h8000_0000;

    accum_state_t     state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] inv_q, inv_d;
    logic             ovf_q, ovf_d;
    f2i_flags_t       flags_q, flags_d;
    f2i_flags_t       beat_flags;
    logic             accept;
    logic             handshake;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sat_sum;
    logic             sat_ovf;

    assign accept     = in_valid && (state_q == ACCUM);
    assign handshake  = (state_q == HOLD) && out_ready;
    assign beat_flags = {in_invalid, in_denorm, in_p_lost};
    assign addend     = {{(ACC_W-32){in_d[31]}}, in_d};

    sat_add_signed #(.W(ACC_W)) u_sat_add (
        .a_i   (sum_q),
        .b_i   (addend),
        .sum_o (sat_sum),
        .ovf_o (sat_ovf)
    );

    // Next-state for the FSM, frame accumulators and sticky flags.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        // A clear that coincides with a beat still lets that beat's flags through.
        flags_d = clr_flags ? f2i_flags_t'(3'b000) : flags_q;
        if (accept) begin
            flags_d = flags_d | beat_flags;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (in_invalid) begin
                if (inv_q != {CNT_W{1'b1}}) inv_d = inv_q + 1'b1;
            end else begin
                sum_d = sat_sum;
                ovf_d = ovf_q | sat_ovf;
            end
            if (in_last) state_d = HOLD;
        end
        if (handshake) begin
            state_d = ACCUM;
            sum_d   = '0;
            cnt_d   = '0;
            inv_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= '0;
            ovf_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            flags_q <= flags_d;
        end
    end

`ifdef F2I_ACCUM_MINMAX_EN
    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;

    // Track extremes of non-invalid beats; reset to the empty-frame sentinels per frame.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (accept && !in_invalid) begin
            if ($signed(in_d) < $signed(min_q)) min_d = in_d;
            if ($signed(in_d) > $signed(max_q)) max_d = in_d;
        end
        if (handshake) begin
            min_d = MIN_INIT;
            max_d = MAX_INIT;
        end
    end

    // Min/max registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= MIN_INIT;
            max_q <= MAX_INIT;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign out_min = min_q;
    assign out_max = max_q;
`endif

    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == HOLD);
    assign out_sum       = sum_q;
    assign out_count     = cnt_q;
    assign out_inv_count = inv_q;
    assign out_ovf       = ovf_q;
    assign sticky_flags  = flags_q;

endmodule

// File: tb/tb_f2i_stream_accum.sv
// Self-checking bench for f2i_stream_accum (ACC_W=33 so saturation is reachable).
module tb_f2i_stream_accum;
    import f2i_pkg::*;

    localparam int ACC_W = 33;
    localparam int CNT_W = 16;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_d = '0;
    logic             in_p_lost = 1'b0;
    logic             in_denorm = 1'b0;
    logic             in_invalid = 1'b0;
    logic             in_last = 1'b0;
    logic             clr_flags = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W-1:0] out_inv_count;
    logic             out_ovf;
    logic [2:0]       sticky_flags;
`ifdef F2I_ACCUM_MINMAX_EN
    logic [31:0]      out_min;
    logic [31:0]      out_max;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: frame totals as plain integers.
    longint m_sum;
    int     m_cnt, m_inv, m_min, m_max;
    bit     m_ovf;
    bit [2:0] m_flags;

    always #5 clk = ~clk;

    f2i_stream_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_d          (in_d),
        .in_p_lost     (in_p_lost),
        .in_denorm     (in_denorm),
        .in_invalid    (in_invalid),
        .in_last       (in_last),
        .clr_flags     (clr_flags),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_count     (out_count),
        .out_inv_count (out_inv_count),
        .out_ovf       (out_ovf),
`ifdef F2I_ACCUM_MINMAX_EN
        .out_min       (out_min),
        .out_max       (out_max),
`endif
        .sticky_flags  (sticky_flags)
    );

    function automatic void model_clear_frame();
        m_sum = 0; m_cnt = 0; m_inv = 0; m_ovf = 0;
        m_min = 32'h7FFF_FFFF;
        m_max = -2147483647 - 1;
    endfunction

    function automatic void model_beat(input logic [31:0] d, input bit pl, dn, inv, clr);
        int sd;
        sd = d;
        if (clr) m_flags = 3'b000;
        m_flags = m_flags | {inv, dn, pl};
        if (m_cnt < 65535) m_cnt++;
        if (inv) begin
            if (m_inv < 65535) m_inv++;
        end else begin
            m_sum = m_sum + longint'(sd);
            if (m_sum > MAXV) begin m_sum = MAXV; m_ovf = 1; end
            if (m_sum < MINV) begin m_sum = MINV; m_ovf = 1; end
            if (sd < m_min) m_min = sd;
            if (sd > m_max) m_max = sd;
        end
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit pl, dn, inv, last, clr);
        in_valid = 1'b1; in_d = d; in_p_lost = pl; in_denorm = dn;
        in_invalid = inv; in_last = last; clr_flags = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; clr_flags = 1'b0;
        in_p_lost = 1'b0; in_denorm = 1'b0; in_invalid = 1'b0;
        model_beat(d, pl, dn, inv, clr);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_clear_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear_frame();
        m_flags = 3'b000;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_handshake: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
        else n_pass++;
        n_total++;
        if ({out_sum, out_count, out_inv_count, out_ovf, sticky_flags} !== '0)
            $display("FAIL reset_values: sum=%0d cnt=%0d inv=%0d ovf=%0b flags=%b want all 0",
                     out_sum, out_count, out_inv_count, out_ovf, sticky_flags);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        send_beat(32'd5, 0, 0, 0, 0, 0);
        send_beat(-32'sd2, 0, 0, 0, 0, 0);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL basic_early_valid: out_valid=%0b want 0", out_valid);
        else n_pass++;
        send_beat(32'd100, 0, 0, 0, 1, 0);
        n_total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_latency: out_valid=%0b in_ready=%0b want 1 0", out_valid, in_ready);
        else n_pass++;
        n_total++;
        if (out_sum !== 33'd103 || out_count !== 16'd3 || out_inv_count !== 16'd0 ||
            out_ovf !== 1'b0 || sticky_flags !== 3'b000)
            $display("FAIL basic_result: sum=%0d cnt=%0d inv=%0d ovf=%0b flags=%b want 103 3 0 0 000",
                     $signed(out_sum), out_count, out_inv_count, out_ovf, sticky_flags);
        else n_pass++;
`ifdef F2I_ACCUM_MINMAX_EN
        n_total++;
        if ($signed(out_min) !== -32'sd2 || out_max !== 32'd100)
            $display("FAIL basic_minmax: min=%0d max=%0d want -2 100", $signed(out_min), $signed(out_max));
        else n_pass++;
`endif
        handshake();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_count !== '0)
            $display("FAIL basic_clear: valid=%0b ready=%0b sum=%0d cnt=%0d want 0 1 0 0",
                     out_valid, in_ready, out_sum, out_count);
        else n_pass++;
    endtask

    task automatic test_invalid_frame();
        send_beat(32'd7, 0, 0, 0, 0, 0);
        send_beat(F2I_INVALID_SENTINEL, 0, 0, 1, 0, 0);
        send_beat(32'd3, 1, 0, 0, 1, 0);
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== 33'd10 || out_count !== 16'd3 ||
            out_inv_count !== 16'd1 || sticky_flags !== 3'b101)
            $display("FAIL invalid_frame: valid=%0b sum=%0d cnt=%0d inv=%0d flags=%b want 1 10 3 1 101",
                     out_valid, $signed(out_sum), out_count, out_inv_count, sticky_flags);
        else n_pass++;
        handshake();
        n_total++;
        if (sticky_flags !== 3'b101)
            $display("FAIL flags_survive_handshake: flags=%b want 101", sticky_flags);
        else n_pass++;
    endtask

    task automatic test_saturation();
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_flags = 3'b000;
        send_beat(32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        send_beat(32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        n_total++;
        if (out_ovf !== 1'b0 || out_sum !== 33'h0_FFFF_FFFE)
            $display("FAIL sat_not_yet: sum=%h ovf=%0b want 0fffffffe 0", out_sum, out_ovf);
        else n_pass++;
        send_beat(32'h7FFF_FFFF, 0, 0, 0, 1, 0);
        n_total++;
        if (out_sum !== 33'h0_FFFF_FFFF || out_ovf !== 1'b1 || out_count !== 16'd3)
            $display("FAIL sat_pos: sum=%h ovf=%0b cnt=%0d want 0ffffffff 1 3", out_sum, out_ovf, out_count);
        else n_pass++;
        handshake();
        for (int i = 0; i < 3; i++) send_beat(32'h8000_0000, 0, 0, 0, 0, 0);
        send_beat(32'd5, 0, 0, 0, 1, 0);
        n_total++;
        if (out_sum !== 33'h1_0000_0005 || out_ovf !== 1'b1 || out_count !== 16'd4)
            $display("FAIL sat_neg: sum=%h ovf=%0b cnt=%0d want 100000005 1 4", out_sum, out_ovf, out_count);
        else n_pass++;
        handshake();
        n_total++;
        if (out_ovf !== 1'b0) $display("FAIL ovf_clear: ovf=%0b want 0", out_ovf);
        else n_pass++;
    endtask

    task automatic test_hold_stall();
        bit stable_ok;
        send_beat(32'd11, 0, 0, 0, 0, 0);
        send_beat(32'd22, 0, 0, 0, 1, 0);
        in_valid = 1'b1; in_d = 32'd999; in_last = 1'b1;
        stable_ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 33'd33 || out_count !== 16'd2)
                stable_ok = 0;
        end
        n_total++;
        if (!stable_ok)
            $display("FAIL hold_stable: ready=%0b valid=%0b sum=%0d cnt=%0d want 0 1 33 2",
                     in_ready, out_valid, out_sum, out_count);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_clear_frame();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_count !== '0)
            $display("FAIL hold_release: valid=%0b ready=%0b sum=%0d cnt=%0d want 0 1 0 0",
                     out_valid, in_ready, out_sum, out_count);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_beat(32'd999, 0, 0, 0, 0);
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== 33'd999 || out_count !== 16'd1)
            $display("FAIL no_bubble: valid=%0b sum=%0d cnt=%0d want 1 999 1", out_valid, out_sum, out_count);
        else n_pass++;
        handshake();
    endtask

    task automatic test_clr_flags();
        send_beat(F2I_INVALID_SENTINEL, 1, 0, 1, 0, 0);
        send_beat(32'd1, 0, 1, 0, 1, 1);
        n_total++;
        if (sticky_flags !== 3'b010)
            $display("FAIL clr_with_beat: flags=%b want 010", sticky_flags);
        else n_pass++;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_flags = 3'b000;
        n_total++;
        if (sticky_flags !== 3'b000)
            $display("FAIL clr_alone: flags=%b want 000", sticky_flags);
        else n_pass++;
        handshake();
    endtask

    task automatic test_rst_in_hold();
        send_beat(32'd42, 1, 1, 0, 1, 0);
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== 33'd42)
            $display("FAIL rst_pre: valid=%0b sum=%0d want 1 42", out_valid, out_sum);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear_frame();
        m_flags = 3'b000;
        n_total++;
        if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1 || sticky_flags !== 3'b000)
            $display("FAIL rst_in_hold: valid=%0b sum=%0d ready=%0b flags=%b want 0 0 1 000",
                     out_valid, out_sum, in_ready, sticky_flags);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                bit inv, pl, dn, clr;
                logic [31:0] d;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                inv = ($urandom_range(0, 3) == 0);
                pl  = ($urandom_range(0, 4) == 0);
                dn  = ($urandom_range(0, 4) == 0);
                clr = ($urandom_range(0, 7) == 0);
                d   = inv ? F2I_INVALID_SENTINEL :
                      ($urandom_range(0, 5) == 0) ? 32'h7FFF_FFFF : $urandom;
                send_beat(d, pl, dn, inv, (b == len - 1), clr);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            n_total++;
            if (out_valid !== 1'b1 || out_sum !== ACC_W'(m_sum) || out_count !== CNT_W'(m_cnt) ||
                out_inv_count !== CNT_W'(m_inv) || out_ovf !== m_ovf || sticky_flags !== m_flags)
                $display("FAIL random_frame%0d: valid=%0b sum=%0d cnt=%0d inv=%0d ovf=%0b flags=%b want 1 %0d %0d %0d %0b %b",
                         f, out_valid, $signed(out_sum), out_count, out_inv_count, out_ovf, sticky_flags,
                         m_sum, m_cnt, m_inv, m_ovf, m_flags);
            else n_pass++;
`ifdef F2I_ACCUM_MINMAX_EN
            n_total++;
            if (out_min !== 32'(m_min) || out_max !== 32'(m_max))
                $display("FAIL random_minmax%0d: min=%0d max=%0d want %0d %0d",
                         f, $signed(out_min), $signed(out_max), m_min, m_max);
            else n_pass++;
`endif
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_invalid_frame();
        test_saturation();
        test_hold_stall();
        test_clr_flags();
        test_rst_in_hold();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
